// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register of the 5-stage MIPS core.
//
// Captures the decoded instruction bundle and passes it to EX one cycle later.
// A branch flush kills the instruction entering EX. A downstream stall holds
// every register.
//
// Optional feature, enabled by the macro ID_EX_HAZARD_DETECT_EN:
//   - load-use hazard detection
//   - one-bubble insertion
//   - a saturating bubble counter
// With the macro undefined, hazard_stall and bubble_cnt are tied to 0.
//
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   id_valid            ID holds a real instruction
//   id_pc4              PC+4 of the ID instruction
//   id_rs_data          register-file read data (rs)
//   id_rt_data          register-file read data (rt)
//   id_imm_ext          sign-extended immediate
//   id_rs, id_rt, id_rd register numbers
//   id_ctrl             control bits:
//                         [0] reg_write   [1] mem_read  [2] mem_write
//                         [3] mem_to_reg  [4] alu_src   [5] reg_dst
//                         [6] branch      [10:7] alu_op
//   ex_stall            EX/MEM cannot accept; hold
//   flush               branch taken in EX; kill the ID instruction
//   ex_*                registered copies of the ID bundle
//   ex_dest             id_rd if reg_dst else id_rt
//   hazard_stall        combinational; upstream holds PC and IF/ID
//   bubble_cnt          saturating count of inserted bubbles
module id_ex_pipe #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm_ext,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [10:0]       id_ctrl,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_dest,
  output logic [10:0]       ex_ctrl,
  output logic              hazard_stall,
  output logic [15:0]       bubble_cnt
);

  logic              r_valid;
  logic [DATA_W-1:0] r_pc4;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [4:0]        r_rs;
  logic [4:0]        r_rt;
  logic [4:0]        r_dest;
  logic [10:0]       r_ctrl;
  logic              w_hazard;

`ifdef ID_EX_HAZARD_DETECT_EN
  logic [15:0] r_bubble_cnt;

  // Load in EX whose target (never r0) feeds a source of the ID instruction.
  // A flush kills the ID instruction, so it cannot be a consumer.
  assign w_hazard = r_valid & r_ctrl[1] & (r_rt != 5'd0) & id_valid &
                    ((r_rt == id_rs) | (r_rt == id_rt)) & ~flush;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_bubble_cnt <= 16'd0;
    end else if (!ex_stall && w_hazard && (r_bubble_cnt != 16'hFFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
`else
  assign w_hazard   = 1'b0;
  assign bubble_cnt = 16'd0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_valid   <= 1'b0;
      r_pc4     <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_rs      <= 5'd0;
      r_rt      <= 5'd0;
      r_dest    <= 5'd0;
      r_ctrl    <= 11'd0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= 11'd0;
    end else if (ex_stall) begin
      // Hold all registers.
    end else if (w_hazard) begin
      // Bubble: fields hold; only valid and control clear.
      r_valid <= 1'b0;
      r_ctrl  <= 11'd0;
    end else begin
      r_valid   <= id_valid;
      r_pc4     <= id_pc4;
      r_rs_data <= id_rs_data;
      r_rt_data <= id_rt_data;
      r_imm     <= id_imm_ext;
      r_rs      <= id_rs;
      r_rt      <= id_rt;
      r_dest    <= id_ctrl[5] ? id_rd : id_rt;
      r_ctrl    <= id_valid ? id_ctrl : 11'd0;
    end
  end

  assign ex_valid     = r_valid;
  assign ex_pc4       = r_pc4;
  assign ex_rs_data   = r_rs_data;
  assign ex_rt_data   = r_rt_data;
  assign ex_imm       = r_imm;
  assign ex_rs        = r_rs;
  assign ex_rt        = r_rt;
  assign ex_dest      = r_dest;
  assign ex_ctrl      = r_ctrl;
  assign hazard_stall = w_hazard;

endmodule

// File: tb/tb_id_ex_pipe.sv
module tb_id_ex_pipe;

`ifdef ID_EX_HAZARD_DETECT_EN
  localparam bit HzEn = 1'b1;
`else
  localparam bit HzEn = 1'b0;
`endif

  localparam logic [10:0] CtrlLw  = 11'h01B;  // reg_write|mem_read|mem_to_reg|alu_src
  localparam logic [10:0] CtrlAdd = 11'h021;  // reg_write|reg_dst
  localparam logic [10:0] CtrlImm = 11'h011;  // reg_write|alu_src

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid;
  logic [31:0] id_pc4, id_rs_data, id_rt_data, id_imm_ext;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [10:0] id_ctrl;
  logic        ex_stall, flush;
  logic        ex_valid;
  logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_dest;
  logic [10:0] ex_ctrl;
  logic        hazard_stall;
  logic [15:0] bubble_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_cnt = 16'd0;

  id_ex_pipe #(.DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_pc4(id_pc4),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm_ext(id_imm_ext),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_ctrl(id_ctrl),
    .ex_stall(ex_stall), .flush(flush), .ex_valid(ex_valid), .ex_pc4(ex_pc4),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest), .ex_ctrl(ex_ctrl),
    .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc4, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [10:0] ctrl);
    id_valid   = v;
    id_pc4     = pc4;
    id_rs_data = pc4 ^ 32'hA5A5_0000;
    id_rt_data = pc4 ^ 32'h0000_5A5A;
    id_imm_ext = pc4 + 32'd16;
    id_rs      = rs;
    id_rt      = rt;
    id_rd      = rd;
    id_ctrl    = ctrl;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ex_stall = 1'b1; flush = 1'b1;
    id_valid = 1'b1; id_pc4 = 32'h1234_5678; id_rs_data = 32'hDEAD_BEEF;
    id_rt_data = 32'hCAFE_F00D; id_imm_ext = 32'h0000_7FFF;
    id_rs = 5'd3; id_rt = 5'd4; id_rd = 5'd7; id_ctrl = 11'h7FF;
    tick();
    n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %h exp 0", ex_valid); end
    n_tests++; if ({ex_pc4, ex_rs_data, ex_rt_data, ex_imm} !== 128'd0) begin n_fail++;
      $display("FAIL rst_data got %h exp 0", {ex_pc4, ex_rs_data, ex_rt_data, ex_imm}); end
    n_tests++; if ({ex_rs, ex_rt, ex_dest, ex_ctrl} !== 26'd0) begin n_fail++;
      $display("FAIL rst_fields got %h exp 0", {ex_rs, ex_rt, ex_dest, ex_ctrl}); end
    n_tests++; if ({hazard_stall, bubble_cnt} !== 17'd0) begin n_fail++;
      $display("FAIL rst_hz_cnt got %h exp 0", {hazard_stall, bubble_cnt}); end
    reset_n = 1'b1; ex_stall = 1'b0; flush = 1'b0;
    id_imm_ext = 32'hFFFF_8241; id_ctrl = CtrlImm;
    tick();
    n_tests++; if (ex_imm !== 32'hFFFF_8241) begin n_fail++; $display("FAIL rel_imm got %h exp FFFF8241", ex_imm); end
    n_tests++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL rel_valid got %h exp 1", ex_valid); end
    n_tests++; if (ex_ctrl !== CtrlImm) begin n_fail++; $display("FAIL rel_ctrl got %h exp %h", ex_ctrl, CtrlImm); end
  endtask

  task automatic test_dest();
    set_id(1'b1, 32'h0000_0104, 5'd2, 5'd5, 5'd9, CtrlAdd);
    tick();
    n_tests++; if (ex_dest !== 5'd9) begin n_fail++; $display("FAIL dest_rd got %0d exp 9", ex_dest); end
    n_tests++; if ({ex_rs, ex_rt} !== {5'd2, 5'd5}) begin n_fail++; $display("FAIL dest_nums got %h exp %h", {ex_rs, ex_rt}, {5'd2, 5'd5}); end
    n_tests++; if ({ex_pc4, ex_rs_data, ex_rt_data} !== {32'h0000_0104, 32'hA5A5_0104, 32'h0000_5B5E}) begin n_fail++;
      $display("FAIL dest_data got %h", {ex_pc4, ex_rs_data, ex_rt_data}); end
    set_id(1'b1, 32'h0000_0108, 5'd2, 5'd5, 5'd9, CtrlImm);
    tick();
    n_tests++; if (ex_dest !== 5'd5) begin n_fail++; $display("FAIL dest_rt got %0d exp 5", ex_dest); end
    // Invalid ID slot loads as an empty bundle with zero control.
    set_id(1'b0, 32'h0000_010C, 5'd1, 5'd1, 5'd1, CtrlAdd);
    tick();
    n_tests++; if ({ex_valid, ex_ctrl} !== 12'd0) begin n_fail++; $display("FAIL inv_ctrl got %h exp 0", {ex_valid, ex_ctrl}); end
  endtask

  task automatic test_load_use();
    set_id(1'b1, 32'h0000_0200, 5'd2, 5'd8, 5'd0, CtrlLw);
    tick();
    set_id(1'b1, 32'h0000_0204, 5'd8, 5'd3, 5'd10, CtrlAdd);
    #1;
    n_tests++; if (hazard_stall !== HzEn) begin n_fail++; $display("FAIL lu_hz got %h exp %h", hazard_stall, HzEn); end
    tick();
    if (HzEn) exp_cnt = exp_cnt + 16'd1;
    n_tests++; if ({ex_valid, ex_ctrl} !== (HzEn ? 12'd0 : {1'b1, CtrlAdd})) begin n_fail++;
      $display("FAIL lu_bubble got %h exp %h", {ex_valid, ex_ctrl}, (HzEn ? 12'd0 : {1'b1, CtrlAdd})); end
    n_tests++; if (ex_rt !== (HzEn ? 5'd8 : 5'd3)) begin n_fail++; $display("FAIL lu_rt_hold got %0d", ex_rt); end
    n_tests++; if (bubble_cnt !== exp_cnt) begin n_fail++; $display("FAIL lu_cnt got %h exp %h", bubble_cnt, exp_cnt); end
    n_tests++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL lu_hz_clear got %h exp 0", hazard_stall); end
    tick();
    n_tests++; if ({ex_valid, ex_ctrl, ex_dest} !== {1'b1, CtrlAdd, 5'd10}) begin n_fail++;
      $display("FAIL lu_load got %h exp %h", {ex_valid, ex_ctrl, ex_dest}, {1'b1, CtrlAdd, 5'd10}); end
    n_tests++; if (bubble_cnt !== exp_cnt) begin n_fail++; $display("FAIL lu_cnt2 got %h exp %h", bubble_cnt, exp_cnt); end
  endtask

  task automatic test_no_false_hazard();
    set_id(1'b1, 32'h0000_0300, 5'd4, 5'd0, 5'd0, CtrlLw);
    tick();
    set_id(1'b1, 32'h0000_0304, 5'd0, 5'd0, 5'd6, CtrlAdd);
    #1;
    n_tests++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL r0_hz got %h exp 0", hazard_stall); end
    tick();
    n_tests++; if ({ex_valid, ex_ctrl, bubble_cnt} !== {1'b1, CtrlAdd, exp_cnt}) begin n_fail++;
      $display("FAIL r0_load got %h exp %h", {ex_valid, ex_ctrl, bubble_cnt}, {1'b1, CtrlAdd, exp_cnt}); end
  endtask

  task automatic test_flush_stall();
    set_id(1'b1, 32'h0000_0400, 5'd1, 5'd8, 5'd0, CtrlLw);
    tick();
    set_id(1'b1, 32'h0000_0404, 5'd8, 5'd2, 5'd11, CtrlAdd);
    flush = 1'b1; ex_stall = 1'b1;
    #1;
    n_tests++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL fl_hz got %h exp 0", hazard_stall); end
    tick();
    n_tests++; if ({ex_valid, ex_ctrl, ex_rt, ex_pc4} !== {12'd0, 5'd8, 32'h0000_0400}) begin n_fail++;
      $display("FAIL fl_kill got %h", {ex_valid, ex_ctrl, ex_rt, ex_pc4}); end
    n_tests++; if (bubble_cnt !== exp_cnt) begin n_fail++; $display("FAIL fl_cnt got %h exp %h", bubble_cnt, exp_cnt); end
    // Stall with pending hazard: hold everything, hazard_stall stays up.
    flush = 1'b0; ex_stall = 1'b0;
    set_id(1'b1, 32'h0000_0500, 5'd1, 5'd8, 5'd0, CtrlLw);
    tick();
    set_id(1'b1, 32'h0000_0504, 5'd2, 5'd8, 5'd12, CtrlAdd);
    ex_stall = 1'b1;
    tick();
    n_tests++; if (hazard_stall !== HzEn) begin n_fail++; $display("FAIL st_hz got %h exp %h", hazard_stall, HzEn); end
    n_tests++; if ({ex_valid, ex_ctrl, ex_pc4, bubble_cnt} !== {1'b1, CtrlLw, 32'h0000_0500, exp_cnt}) begin n_fail++;
      $display("FAIL st_hold got %h", {ex_valid, ex_ctrl, ex_pc4, bubble_cnt}); end
    ex_stall = 1'b0;
    tick();
    if (HzEn) exp_cnt = exp_cnt + 16'd1;
    n_tests++; if ({ex_valid, ex_ctrl, bubble_cnt} !== (HzEn ? {12'd0, exp_cnt} : {1'b1, CtrlAdd, exp_cnt})) begin n_fail++;
      $display("FAIL st_release got %h", {ex_valid, ex_ctrl, bubble_cnt}); end
    tick();
    n_tests++; if ({ex_valid, ex_ctrl, ex_dest} !== {1'b1, CtrlAdd, 5'd12}) begin n_fail++;
      $display("FAIL st_load got %h", {ex_valid, ex_ctrl, ex_dest}); end
  endtask

  task automatic test_saturation();
`ifdef ID_EX_HAZARD_DETECT_EN
    force dut.r_bubble_cnt = 16'hFFFE;
    #1;
    release dut.r_bubble_cnt;
    exp_cnt = 16'hFFFE;
`endif
    for (int k = 0; k < 2; k++) begin
      set_id(1'b1, 32'h0000_0600, 5'd1, 5'd9, 5'd0, CtrlLw);
      tick();
      set_id(1'b1, 32'h0000_0604, 5'd9, 5'd2, 5'd13, CtrlAdd);
      tick();
      if (HzEn) exp_cnt = 16'hFFFF;
      n_tests++; if (bubble_cnt !== exp_cnt) begin n_fail++; $display("FAIL sat_%0d got %h exp %h", k, bubble_cnt, exp_cnt); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    set_id(1'b1, 32'h0000_0700, 5'd1, 5'd7, 5'd0, CtrlLw);
    tick();
    set_id(1'b1, 32'h0000_0704, 5'd7, 5'd2, 5'd14, CtrlAdd);
    reset_n = 1'b0; flush = 1'b1; ex_stall = 1'b1;
    tick();
    exp_cnt = 16'd0;
    n_tests++; if ({ex_valid, ex_ctrl, ex_pc4, ex_rt, hazard_stall, bubble_cnt} !== 66'd0) begin n_fail++;
      $display("FAIL mid_rst got %h exp 0", {ex_valid, ex_ctrl, ex_pc4, ex_rt, hazard_stall, bubble_cnt}); end
    reset_n = 1'b1; flush = 1'b0; ex_stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_dest();
    test_load_use();
    test_no_false_hazard();
    test_flush_stall();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
